// File: rtl/polar_pkg.sv
// ---------------------------------------------------------------------------
// polar_pkg
// Shared types and constants for the serial polar encoder.
//   state_e           : frame FSM states (load message, encode, stream out)
//   POLAR_N_LOG2_MAX  : largest supported log2 of the code length
// ---------------------------------------------------------------------------
package polar_pkg;

    localparam int POLAR_N_LOG2_MAX = 10;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_ENC  = 2'd1,
        S_OUT  = 2'd2
    } state_e;

endpackage

// File: rtl/polar_butterfly_stage.sv
// ---------------------------------------------------------------------------
// polar_butterfly_stage
// One in-place butterfly stage of the polar transform x = u * F^(xn),
// F = [1 0; 1 1], natural order. Purely combinational.
//   data_i  [N-1:0]      : current buffer contents
//   stage_i [N_LOG2-1:0] : stage index s (0 .. N_LOG2-1)
//   data_o  [N-1:0]      : buffer after the stage; for every i whose bit s is
//                          0, data_o[i] = data_i[i] ^ data_i[i + 2**s]
// ---------------------------------------------------------------------------
module polar_butterfly_stage #(
    parameter int N_LOG2 = 3
) (
    input  logic [(2**N_LOG2)-1:0] data_i,
    input  logic [N_LOG2-1:0]      stage_i,
    output logic [(2**N_LOG2)-1:0] data_o
);

    localparam int N = 2**N_LOG2;
    localparam logic [N_LOG2-1:0] ONE = N_LOG2'(1);

    logic [N_LOG2-1:0] stage_bit;

    assign stage_bit = ONE << stage_i;

    for (genvar i = 0; i < N; i++) begin : g_bfly
        localparam logic [N_LOG2-1:0] IDX = N_LOG2'(i);
        logic [N_LOG2-1:0] partner;

        // OR-ing in the stage bit yields i + 2**s whenever bit s of i is 0,
        // and stays inside the buffer for any stage value.
        assign partner   = IDX | stage_bit;
        assign data_o[i] = ((IDX & stage_bit) != '0) ? data_i[i]
                                                     : data_i[i] ^ data_i[partner];
    end

endmodule

// File: rtl/polar_encoder.sv
// ---------------------------------------------------------------------------
// polar_encoder
// Serial-in / serial-out polar encoder, x = u * F^(xn), natural order.
// Collects N = 2**N_LOG2 message bits, runs N_LOG2 butterfly stages (one per
// cycle) in place, then streams the N code bits with valid/ready handshake.
//
// Parameters
//   N_LOG2       : log2 of code length, 1 .. POLAR_N_LOG2_MAX
//   FROZEN_MASK  : bit i = 1 marks u[i] as frozen to 0 (only with macro)
// Build option
//   POLAR_FROZEN_EN : when defined, frozen positions are filled with 0 without
//                     consuming input; only info positions take in_bit.
// Ports
//   clk        in  : clock, all logic on posedge
//   rst        in  : synchronous active-high reset
//   in_valid   in  : in_bit carries a message bit
//   in_ready   out : block accepts in_bit this cycle
//   in_bit     in  : message bit, first accepted bit of a frame is u[0]
//   out_valid  out : out_bit carries a code bit
//   out_ready  in  : downstream accepts out_bit this cycle
//   out_bit    out : code bit, first emitted is x[0]
//   out_last   out : high together with x[N-1]
//   busy       out : high while encoding or streaming
// ---------------------------------------------------------------------------
module polar_encoder
    import polar_pkg::*;
#(
    parameter int                    N_LOG2      = 3,
    parameter logic [(2**N_LOG2)-1:0] FROZEN_MASK = 8'b0001_0111
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    input  logic in_bit,
    output logic out_valid,
    input  logic out_ready,
    output logic out_bit,
    output logic out_last,
    output logic busy
);

    localparam int N = 2**N_LOG2;
    localparam logic [N_LOG2-1:0] IDX_LAST = '1;
    localparam logic [N_LOG2-1:0] STG_LAST = N_LOG2'(N_LOG2 - 1);
    localparam logic [N_LOG2-1:0] IDX_ONE  = N_LOG2'(1);

    if (N_LOG2 < 1 || N_LOG2 > POLAR_N_LOG2_MAX) begin : g_bad_n_log2
        $error("polar_encoder: N_LOG2 out of range");
    end

`ifdef POLAR_FROZEN_EN
    localparam logic [N-1:0] FROZEN = FROZEN_MASK;
`else
    // Mask has no effect in this build: every position is an info position.
    localparam logic [N-1:0] FROZEN = FROZEN_MASK & '0;
`endif

    state_e            state_q, state_d;
    logic [N-1:0]      data_q;
    logic [N-1:0]      data_enc;
    logic [N_LOG2-1:0] wr_idx_q;
    logic [N_LOG2-1:0] stg_q;
    logic [N_LOG2-1:0] rd_idx_q;

    logic cur_frozen;
    logic load_step;
    logic wr_last;
    logic stg_last;
    logic rd_last;
    logic out_fire;

    // A frozen position advances on its own; an info position waits for data.
    assign cur_frozen = FROZEN[wr_idx_q];
    assign load_step  = (state_q == S_LOAD) && (cur_frozen || in_valid);
    assign wr_last    = (wr_idx_q == IDX_LAST);
    assign stg_last   = (stg_q == STG_LAST);
    assign rd_last    = (rd_idx_q == IDX_LAST);
    assign out_fire   = (state_q == S_OUT) && out_ready;

    polar_butterfly_stage #(
        .N_LOG2 (N_LOG2)
    ) u_stage (
        .data_i  (data_q),
        .stage_i (stg_q),
        .data_o  (data_enc)
    );

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD:  if (load_step && wr_last)  state_d = S_ENC;
            S_ENC:   if (stg_last)              state_d = S_OUT;
            S_OUT:   if (out_fire && rd_last)   state_d = S_LOAD;
            default:                            state_d = S_LOAD;
        endcase
    end

    // Outputs, decoded from state and registers only.
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_bit   = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        case (state_q)
            S_LOAD: in_ready = !cur_frozen;
            S_ENC:  busy     = 1'b1;
            S_OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_bit   = data_q[rd_idx_q];
                out_last  = rd_last;
            end
            default: ;
        endcase
    end

    // Frame buffer and counters. Each counter returns to 0 explicitly after
    // its terminal value so the next frame always starts from index 0.
    // NOTE: the frame buffer is a small flop vector, not a RAM, so it is
    // cleared by reset together with the counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q   <= '0;
            wr_idx_q <= '0;
            stg_q    <= '0;
            rd_idx_q <= '0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (load_step) begin
                        data_q[wr_idx_q] <= in_bit & ~cur_frozen;
                        wr_idx_q         <= wr_last ? '0 : wr_idx_q + IDX_ONE;
                    end
                end
                S_ENC: begin
                    data_q <= data_enc;
                    stg_q  <= stg_last ? '0 : stg_q + IDX_ONE;
                end
                S_OUT: begin
                    if (out_fire) begin
                        rd_idx_q <= rd_last ? '0 : rd_idx_q + IDX_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
